// File: rtl/digit_code_checker_pkg.sv
// Shared definitions for the digit code checker: FSM state encoding and BCD nibble width.
package digit_code_checker_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_CHECK    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_LOCKOUT  = 2'd3
    } state_t;

endpackage

// File: rtl/digit_code_checker_if.sv
// Link between the seven-segment drawing grid and the code checker.
interface digit_code_checker_if;
    import digit_code_checker_pkg::*;

    logic                digit_valid;
    logic [NIBBLE_W-1:0] digit_value;
    logic                grid_enable;

    // master = grid side, slave = checker side
    modport master (output digit_valid, output digit_value, input grid_enable);
    modport slave  (input digit_valid, input digit_value, output grid_enable);

endinterface

// File: rtl/digit_code_checker_btn_edge_detect.sv
// Registers a synchronised button level and flags its rising edge.
module btn_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic btn,
    output logic rise
);

    logic btn_prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            btn_prev <= 1'b0;
        end else begin
            btn_prev <= btn;
        end
    end

    assign rise = btn & ~btn_prev;

endmodule

// File: rtl/digit_code_checker.sv
// Collects committed digits from the drawing grid, checks the code against a target,
// and manages attempts, unlock and timed lockout.
module digit_code_checker
    import digit_code_checker_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 31250000
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           confirm_btn,
    input  logic                           clear_btn,
    digit_code_checker_if.slave            grid,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] target_code,
    output logic [NIBBLE_W*NUM_DIGITS-1:0] entered_code,
    output logic [2:0]                     digit_count,
    output logic [2:0]                     attempts_left,
    output logic                           unlocked,
    output logic                           locked_out,
    output logic                           accept_pulse,
    output logic                           reject_pulse,
    output logic                           error_pulse
);

    localparam int CODE_W = NIBBLE_W * NUM_DIGITS;
    localparam int CNT_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [2:0]       FULL_COUNT = 3'(NUM_DIGITS);
    localparam logic [2:0]       ATT_RELOAD = 3'(MAX_ATTEMPTS);
    localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCKOUT_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  lock_cnt;
    logic              grid_enable_r;
    logic              confirm_evt;
    logic              clear_evt;
    logic [CODE_W-1:0] next_code;

    btn_edge_detect u_confirm_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .btn     (confirm_btn),
        .rise    (confirm_evt)
    );

    btn_edge_detect u_clear_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .btn     (clear_btn),
        .rise    (clear_evt)
    );

    // Oldest digit shifts toward the MSB; the truncation drops the nibble pushed out the top.
    assign next_code        = CODE_W'({entered_code, grid.digit_value});
    assign grid.grid_enable = grid_enable_r;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_ENTRY;
            lock_cnt      <= '0;
            grid_enable_r <= 1'b1;
            entered_code  <= '0;
            digit_count   <= '0;
            attempts_left <= ATT_RELOAD;
            unlocked      <= 1'b0;
            locked_out    <= 1'b0;
            accept_pulse  <= 1'b0;
            reject_pulse  <= 1'b0;
            error_pulse   <= 1'b0;
        end else begin
            accept_pulse <= 1'b0;
            reject_pulse <= 1'b0;
            error_pulse  <= 1'b0;

            case (state)
                ST_ENTRY: begin
                    grid_enable_r <= 1'b1;
                    if (digit_count == FULL_COUNT) begin
                        state         <= ST_CHECK;
                        grid_enable_r <= 1'b0;
                    end else if (clear_evt) begin
                        entered_code  <= '0;
                        digit_count   <= '0;
                        grid_enable_r <= 1'b0;
                    end else if (confirm_evt) begin
                        if (grid.digit_valid) begin
                            entered_code  <= next_code;
                            digit_count   <= digit_count + 3'd1;
                            accept_pulse  <= 1'b1;
                            grid_enable_r <= 1'b0;
                        end else begin
                            reject_pulse <= 1'b1;
                        end
                    end
                end

                ST_CHECK: begin
                    if (entered_code == target_code) begin
                        state    <= ST_UNLOCKED;
                        unlocked <= 1'b1;
                    end else begin
                        error_pulse   <= 1'b1;
                        entered_code  <= '0;
                        digit_count   <= '0;
                        attempts_left <= attempts_left - 3'd1;
                        if (attempts_left == 3'd1) begin
                            state      <= ST_LOCKOUT;
                            lock_cnt   <= LOCK_LOAD;
                            locked_out <= 1'b1;
                        end else begin
                            state         <= ST_ENTRY;
                            grid_enable_r <= 1'b1;
                        end
                    end
                end

                ST_UNLOCKED: begin
                    if (clear_evt) begin
                        state         <= ST_ENTRY;
                        attempts_left <= ATT_RELOAD;
                        entered_code  <= '0;
                        digit_count   <= '0;
                        unlocked      <= 1'b0;
                        grid_enable_r <= 1'b1;
                    end
                end

                ST_LOCKOUT: begin
                    if (lock_cnt == '0) begin
                        state         <= ST_ENTRY;
                        attempts_left <= ATT_RELOAD;
                        locked_out    <= 1'b0;
                        grid_enable_r <= 1'b1;
                    end else begin
                        lock_cnt <= lock_cnt - 1'b1;
                    end
                end

                default: state <= ST_ENTRY;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_code_checker.sv
// Directed bench for digit_code_checker: table-driven entry/unlock sequence plus lockout and reset corners.
module tb_digit_code_checker;
    import digit_code_checker_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        confirm_btn = 1'b0;
    logic        clear_btn = 1'b0;
    logic [15:0] target_code = 16'h1234;
    logic [15:0] entered_code;
    logic [2:0]  digit_count;
    logic [2:0]  attempts_left;
    logic        unlocked, locked_out, accept_pulse, reject_pulse, error_pulse;

    int errors = 0;
    int checks = 0;

    digit_code_checker_if gif ();

    digit_code_checker #(
        .NUM_DIGITS     (4),
        .MAX_ATTEMPTS   (3),
        .LOCKOUT_CYCLES (20)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .confirm_btn   (confirm_btn),
        .clear_btn     (clear_btn),
        .grid          (gif.slave),
        .target_code   (target_code),
        .entered_code  (entered_code),
        .digit_count   (digit_count),
        .attempts_left (attempts_left),
        .unlocked      (unlocked),
        .locked_out    (locked_out),
        .accept_pulse  (accept_pulse),
        .reject_pulse  (reject_pulse),
        .error_pulse   (error_pulse)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        conf;
        logic        clr;
        logic        valid;
        logic [3:0]  val;
        logic        acc;
        logic        rej;
        logic        ge;
        logic        unl;
        logic [2:0]  cnt;
        logic [15:0] code;
        logic [2:0]  att;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic enter_digit(input logic [3:0] v);
        gif.digit_valid = 1'b1;
        gif.digit_value = v;
        confirm_btn = 1'b1;
        tick();
        confirm_btn = 1'b0;
        tick();
    endtask

    // Enters a wrong code and steps through CHECK to the cycle where the error is reported.
    task automatic wrong_code(input int idx, input logic [2:0] exp_att);
        for (int d = 0; d < 4; d++) enter_digit(4'd9);
        tick();
        check($sformatf("err_pulse%0d", idx), {31'd0, error_pulse}, 32'd1);
        check($sformatf("err_att%0d", idx), {29'd0, attempts_left}, {29'd0, exp_att});
        check($sformatf("err_cnt%0d", idx), {29'd0, digit_count}, 32'd0);
        check($sformatf("err_lock%0d", idx), {31'd0, locked_out}, {31'd0, (exp_att == 3'd0)});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int acc_seen;

        gif.digit_valid = 1'b0;
        gif.digit_value = 4'd0;

        vecs[0]  = '{1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0001, 3'd3};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 16'h0001, 3'd3};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 16'h0001, 3'd3};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 16'h0001, 3'd3};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 16'h0012, 3'd3};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 16'h0012, 3'd3};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd3};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 3'd3};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0001, 3'd3};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 16'h0001, 3'd3};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 16'h0012, 3'd3};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 16'h0012, 3'd3};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 16'h0123, 3'd3};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 16'h0123, 3'd3};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 16'h1234, 3'd3};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 16'h1234, 3'd3};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 16'h1234, 3'd3};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 16'h1234, 3'd3};
        vecs[18] = '{1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 3'd3};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 3'd3};

        // Reset state
        repeat (3) @(posedge clock);
        #2;
        check("rst_ge", {31'd0, gif.grid_enable}, 32'd1);
        check("rst_code", {16'd0, entered_code}, 32'd0);
        check("rst_cnt", {29'd0, digit_count}, 32'd0);
        check("rst_att", {29'd0, attempts_left}, 32'd3);
        check("rst_flags", {27'd0, unlocked, locked_out, accept_pulse, reject_pulse, error_pulse}, 32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 20; i++) begin
            confirm_btn     = vecs[i].conf;
            clear_btn       = vecs[i].clr;
            gif.digit_valid = vecs[i].valid;
            gif.digit_value = vecs[i].val;
            tick();
            check($sformatf("v%0d_acc", i), {31'd0, accept_pulse}, {31'd0, vecs[i].acc});
            check($sformatf("v%0d_rej", i), {31'd0, reject_pulse}, {31'd0, vecs[i].rej});
            check($sformatf("v%0d_ge", i), {31'd0, gif.grid_enable}, {31'd0, vecs[i].ge});
            check($sformatf("v%0d_unl", i), {31'd0, unlocked}, {31'd0, vecs[i].unl});
            check($sformatf("v%0d_cnt", i), {29'd0, digit_count}, {29'd0, vecs[i].cnt});
            check($sformatf("v%0d_code", i), {16'd0, entered_code}, {16'd0, vecs[i].code});
            check($sformatf("v%0d_att", i), {29'd0, attempts_left}, {29'd0, vecs[i].att});
            check($sformatf("v%0d_err", i), {31'd0, error_pulse}, 32'd0);
        end

        // Held confirm produces a single commit
        gif.digit_valid = 1'b1;
        gif.digit_value = 4'd5;
        confirm_btn = 1'b1;
        acc_seen = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (accept_pulse) acc_seen++;
        end
        check("hold_accepts", acc_seen, 32'd1);
        check("hold_cnt", {29'd0, digit_count}, 32'd1);
        check("hold_code", {16'd0, entered_code}, 32'h0005);
        confirm_btn = 1'b0;
        tick();
        clear_btn = 1'b1;
        tick();
        check("clr_cnt", {29'd0, digit_count}, 32'd0);
        clear_btn = 1'b0;
        tick();

        // Three wrong codes then a full lockout with confirms toggling
        wrong_code(0, 3'd2);
        wrong_code(1, 3'd1);
        wrong_code(2, 3'd0);
        n = 0;
        acc_seen = 0;
        while (locked_out && n < 100) begin
            n++;
            confirm_btn = n[0];
            if (accept_pulse) acc_seen++;
            tick();
        end
        confirm_btn = 1'b0;
        check("lock_cycles", n, 32'd20);
        check("lock_no_accept", acc_seen, 32'd0);
        check("lock_exit_att", {29'd0, attempts_left}, 32'd3);
        check("lock_exit_cnt", {29'd0, digit_count}, 32'd0);
        check("lock_exit_ge", {31'd0, gif.grid_enable}, 32'd1);
        tick();

        // Asynchronous reset part-way through a second lockout
        wrong_code(3, 3'd2);
        wrong_code(4, 3'd1);
        wrong_code(5, 3'd0);
        repeat (9) tick();
        check("mid_lock", {31'd0, locked_out}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_lock", {31'd0, locked_out}, 32'd0);
        check("arst_att", {29'd0, attempts_left}, 32'd3);
        check("arst_ge", {31'd0, gif.grid_enable}, 32'd1);
        check("arst_err", {31'd0, error_pulse}, 32'd0);
        #2;
        reset_n = 1'b1;
        tick();
        check("post_rst_lock", {31'd0, locked_out}, 32'd0);
        gif.digit_valid = 1'b1;
        gif.digit_value = 4'd3;
        confirm_btn = 1'b1;
        tick();
        check("post_rst_acc", {31'd0, accept_pulse}, 32'd1);
        check("post_rst_code", {16'd0, entered_code}, 32'h0003);
        confirm_btn = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
